// File: rtl/blob_centroid_tracker_pkg.sv
// blob_centroid_tracker shared geometry, widths, FSM encoding and helpers.
// The overlay colour and near1() serve the CENTROID_OVERLAY_EN build.
package blob_centroid_tracker_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int COORD_W    = 10;
  localparam int CNT_W      = 19;
  localparam int SUM_W      = 28;
  localparam int MIN_PIXELS = 64;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t DIV_X = 2'd1;
  localparam state_t DIV_Y = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef logic [23:0] rgb_t;
  localparam rgb_t OVL_COLOR = 24'hFF00FF;

  function automatic logic near1(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    return (a == b)
        || (a + COORD_W'(1) == b)
        || (b + COORD_W'(1) == a);
  endfunction
endpackage

// File: rtl/blob_centroid_tracker_seq_udivider.sv
// Restoring unsigned divider, one quotient bit per clock.
// start loads operands; done pulses once after the last bit.
module seq_udivider
  import blob_centroid_tracker_pkg::*;
#(
  parameter int N_W = SUM_W,
  parameter int D_W = CNT_W,
  parameter int Q_W = COORD_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [Q_W-1:0] quotient,
  output logic           done
);
  localparam int C_W = $clog2(N_W);

  logic [N_W-1:0] quo;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] dvs;
  logic [C_W-1:0] cnt;
  logic           busy;
  logic [D_W:0]   rem_sh;
  logic [D_W:0]   diff;

  assign rem_sh = {rem, quo[N_W-1]};
  // Borrow out of the trial subtract means the bit is 0.
  assign diff   = rem_sh - {1'b0, dvs};
  assign quotient = quo[Q_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (diff[D_W]) begin
        rem <= rem_sh[D_W-1:0];
        quo <= {quo[N_W-2:0], 1'b0};
      end else begin
        rem <= diff[D_W-1:0];
        quo <= {quo[N_W-2:0], 1'b1};
      end
      cnt <= cnt + C_W'(1);
      if (cnt == C_W'(N_W-1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/blob_centroid_tracker.sv
// Blob centroid tracker: RGB window match, per-frame sums, sequential divide.
// Define CENTROID_OVERLAY_EN to draw a magenta crosshair on oR/oG/oB.
module blob_centroid_tracker
  import blob_centroid_tracker_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int V_ACT = V_ACTIVE
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iDE,
  input  logic               iVS,
  input  logic [7:0]         iR,
  input  logic [7:0]         iG,
  input  logic [7:0]         iB,
  input  logic [23:0]        iLO,
  input  logic [23:0]        iHI,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic [CNT_W-1:0]   oCount,
  output logic               oFound,
  output logic               oValid,
  output logic               oBusy,
  output logic               oDropped,
  output logic [7:0]         oR,
  output logic [7:0]         oG,
  output logic [7:0]         oB
);
  state_t state;
  logic vs_q, de_q, kick;
  logic [COORD_W-1:0] x, y;
  logic x_over, y_over;
  logic [CNT_W-1:0] cnt, snap_cnt;
  logic [SUM_W-1:0] sx, sy, snap_sx, snap_sy;
  logic [COORD_W-1:0] q_x, div_q;
  logic div_start, div_done;
  logic idle, close, in_window, match, hit;

  assign idle  = (state == IDLE);
  assign close = vs_q & ~iVS;
  assign oBusy = ~idle;

  assign in_window = (iR >= iLO[23:16]) && (iR <= iHI[23:16])
                  && (iG >= iLO[15:8])  && (iG <= iHI[15:8])
                  && (iB >= iLO[7:0])   && (iB <= iHI[7:0]);
  assign match = iDE && !x_over && !y_over && in_window;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      x      <= '0;
      y      <= '0;
      x_over <= 1'b0;
      y_over <= 1'b0;
    end else begin
      vs_q <= iVS;
      de_q <= iDE;
      if (iDE) begin
        if (x == COORD_W'(H_ACT-1)) x_over <= 1'b1;
        else x <= x + COORD_W'(1);
      end else if (de_q) begin
        x      <= '0;
        x_over <= 1'b0;
      end
      if (close) begin
        y      <= '0;
        y_over <= 1'b0;
      end else if (de_q && !iDE) begin
        if (y == COORD_W'(V_ACT-1)) y_over <= 1'b1;
        else y <= y + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt      <= '0;
      sx       <= '0;
      sy       <= '0;
      snap_cnt <= '0;
      snap_sx  <= '0;
      snap_sy  <= '0;
    end else if (close) begin
      cnt <= '0;
      sx  <= '0;
      sy  <= '0;
      if (idle) begin
        snap_cnt <= cnt;
        snap_sx  <= sx;
        snap_sy  <= sy;
      end
    end else if (match) begin
      cnt <= cnt + CNT_W'(1);
      sx  <= sx + SUM_W'(x);
      sy  <= sy + SUM_W'(y);
    end
  end

  // X divide starts the cycle after the snapshot, Y as soon as X finishes.
  assign div_start = kick | ((state == DIV_X) & div_done);

  seq_udivider #(
    .N_W(SUM_W),
    .D_W(CNT_W),
    .Q_W(COORD_W)
  ) u_div (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .start   (div_start),
    .dividend(kick ? snap_sx : snap_sy),
    .divisor (snap_cnt),
    .quotient(div_q),
    .done    (div_done)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      kick     <= 1'b0;
      q_x      <= '0;
      oX       <= '0;
      oY       <= '0;
      oCount   <= '0;
      oFound   <= 1'b0;
      oValid   <= 1'b0;
      oDropped <= 1'b0;
    end else begin
      kick     <= close & idle;
      oDropped <= close & ~idle;
      oValid   <= 1'b0;
      unique case (state)
        IDLE: if (close) state <= DIV_X;
        DIV_X: if (div_done) begin
          q_x   <= div_q;
          state <= DIV_Y;
        end
        DIV_Y: if (div_done) begin
          state  <= DONE;
          oValid <= 1'b1;
          oCount <= snap_cnt;
          if (snap_cnt >= CNT_W'(MIN_PIXELS)) begin
            oX     <= q_x;
            oY     <= div_q;
            oFound <= 1'b1;
          end else begin
            oFound <= 1'b0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

`ifdef CENTROID_OVERLAY_EN
  assign hit = oFound && iDE && (near1(x, oX) || near1(y, oY));
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) {oR, oG, oB} <= '0;
    else if (hit) {oR, oG, oB} <= OVL_COLOR;
    else {oR, oG, oB} <= {iR, iG, iB};
  end
endmodule
